// File: rtl/joystick_pkg.sv
// Shared definitions for the joystick SPI responder: frame size, LED command prefix,
// responder states and the byte map of the reply frame.
package joystick_pkg;

    localparam int          JSTK_NUM_BYTES = 5;
    localparam logic [5:0]  LED_CMD_PREFIX = 6'b100000;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_END       = 2'd3
    } jstk_state_e;

    function automatic logic [7:0] frame_byte(
        input logic [3:0] idx,
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [2:0] b
    );
        logic [7:0] v;
        case (idx)
            4'd0:    v = x[7:0];
            4'd1:    v = {6'b000000, x[9:8]};
            4'd2:    v = y[7:0];
            4'd3:    v = {6'b000000, y[9:8]};
            4'd4:    v = {5'b00000, b};
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/joystick_spi_responder_if.sv
// SPI wires between the joystick master and the responder.
interface joystick_spi_responder_if;
    import joystick_pkg::*;

    logic joystick_SS;
    logic joystick_SCLK;
    logic joystick_MOSI;
    logic joystick_MISO;

    modport master (output joystick_SS, output joystick_SCLK, output joystick_MOSI, input joystick_MISO);
    modport slave  (input joystick_SS, input joystick_SCLK, input joystick_MOSI, output joystick_MISO);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous SPI wire with rise/fall pulses on the
// synchronized value.
module spi_sync_edge
    import joystick_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;
endmodule

// File: rtl/joystick_spi_responder.sv
// SPI-slave stand-in for the joystick Pmod: replies with programmable X/Y/button bytes
// and latches the LED command carried in the first byte of a valid frame.
module joystick_spi_responder
    import joystick_pkg::*;
#(
    parameter int NUM_BYTES   = JSTK_NUM_BYTES,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [9:0]               x_pos,
    input  logic [9:0]               y_pos,
    input  logic [2:0]               btn,
    joystick_spi_responder_if.slave  spi,
    output logic [1:0]               led,
    output logic                     frame_done,
    output logic                     frame_err
);
    localparam logic [3:0] NB_IDX = 4'(NUM_BYTES);
    localparam logic [2:0] NB_CNT = 3'(NUM_BYTES);

    jstk_state_e r_state;
    jstk_state_e w_state_next;

    logic w_ss_q, w_ss_rise, w_ss_fall;
    logic w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    logic [7:0] r_tx_sr, r_rx_sr, r_cmd;
    logic [3:0] r_bit_cnt;
    logic [2:0] r_byte_cnt;
    logic [9:0] r_x, r_y;
    logic [2:0] r_btn;
    logic       r_miso, r_frame_done, r_frame_err;
    logic [1:0] r_led;

    logic [3:0] w_next_idx;
    logic [7:0] w_next_byte, w_b0;
    logic       w_valid;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk(clk), .rst(rst), .i_d(spi.joystick_SS),
        .o_q(w_ss_q), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .rst(rst), .i_d(spi.joystick_SCLK),
        .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    // MOSI synchronizer, same depth as SCLK so data lines up with the detected edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.joystick_MOSI};
        end
    end

    // Byte index widened so a saturated byte counter cannot wrap back to B0
    assign w_next_idx  = {1'b0, r_byte_cnt} + 4'd1;
    assign w_next_byte = (w_next_idx >= NB_IDX) ? 8'h00 : frame_byte(w_next_idx, r_x, r_y, r_btn);
    assign w_b0        = frame_byte(4'd0, x_pos, y_pos, btn);
    assign w_valid     = (r_byte_cnt == NB_CNT) && (r_bit_cnt == 4'd0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_WAIT_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; SS rise beats any SCLK edge in the same cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_WAIT_IDLE: if (w_ss_q)    w_state_next = ST_IDLE;  else w_state_next = ST_WAIT_IDLE;
            ST_IDLE:      if (w_ss_fall) w_state_next = ST_SHIFT; else w_state_next = ST_IDLE;
            ST_SHIFT:     if (w_ss_rise) w_state_next = ST_END;   else w_state_next = ST_SHIFT;
            ST_END:       w_state_next = ST_IDLE;
            default:      w_state_next = ST_WAIT_IDLE;
        endcase
    end

    // Shift registers, counters, snapshot and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_sr <= 8'h00; r_rx_sr <= 8'h00; r_cmd <= 8'h00;
            r_bit_cnt <= 4'd0; r_byte_cnt <= 3'd0;
            r_x <= 10'd0; r_y <= 10'd0; r_btn <= 3'd0;
            r_miso <= 1'b0; r_led <= 2'b00;
            r_frame_done <= 1'b0; r_frame_err <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                ST_WAIT_IDLE: r_miso <= 1'b0;
                ST_IDLE: begin
                    if (w_ss_fall) begin
                        r_x <= x_pos; r_y <= y_pos; r_btn <= btn;
                        r_tx_sr <= w_b0;
                        r_miso <= w_b0[7];
                        r_bit_cnt <= 4'd0;
                        r_byte_cnt <= 3'd0;
                    end else begin
                        r_miso <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (w_ss_rise) begin
                        r_miso <= r_miso;
                    end else if (w_sclk_rise && w_sclk_q) begin
                        r_rx_sr <= {r_rx_sr[6:0], r_mosi_sync[SYNC_STAGES-1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end else if (w_sclk_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            r_byte_cnt <= (r_byte_cnt == 3'd7) ? 3'd7 : r_byte_cnt + 3'd1;
                            r_bit_cnt <= 4'd0;
                            if (r_byte_cnt == 3'd0) r_cmd <= r_rx_sr; else r_cmd <= r_cmd;
                            r_tx_sr <= w_next_byte;
                            r_miso <= w_next_byte[7];
                        end else begin
                            r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                            r_miso <= r_tx_sr[6];
                        end
                    end else begin
                        r_miso <= r_miso;
                    end
                end
                ST_END: begin
                    r_miso <= 1'b0;
                    if (w_valid) begin
                        r_frame_done <= 1'b1;
                        if (r_cmd[7:2] == LED_CMD_PREFIX) r_led <= r_cmd[1:0]; else r_led <= r_led;
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end
                default: r_miso <= 1'b0;
            endcase
        end
    end

    assign spi.joystick_MISO = r_miso;
    assign led               = r_led;
    assign frame_done        = r_frame_done;
    assign frame_err         = r_frame_err;
endmodule

// File: tb/tb_joystick_spi_responder.sv
// Directed bench for joystick_spi_responder: acts as the SPI master, scoreboards the
// reply bytes and tracks frame_done/frame_err/led against a reference model.
module tb_joystick_spi_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x_pos, y_pos;
    logic [2:0] btn;
    logic [1:0] led;
    logic       frame_done, frame_err;

    joystick_spi_responder_if spi_if ();

    joystick_spi_responder dut (
        .clk(clk), .rst(rst), .x_pos(x_pos), .y_pos(y_pos), .btn(btn),
        .spi(spi_if.slave), .led(led), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [7:0] exp_q [$];
    logic [1:0] exp_led;

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
    end

    function automatic logic [7:0] model_byte(input int idx, input logic [9:0] x,
                                              input logic [9:0] y, input logic [2:0] b);
        case (idx)
            0: return x[7:0];
            1: return {6'b000000, x[9:8]};
            2: return y[7:0];
            3: return {6'b000000, y[9:8]};
            4: return {5'b00000, b};
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic shift_byte(input logic [7:0] mo, output logic [7:0] mi);
        mi = 8'h00;
        for (int b = 7; b >= 0; b--) begin
            spi_if.joystick_MOSI = mo[b];
            #80;
            spi_if.joystick_SCLK = 1'b1;
            mi = {mi[6:0], spi_if.joystick_MISO};
            #80;
            spi_if.joystick_SCLK = 1'b0;
        end
    endtask

    task automatic wait_end(input int d0, input int e0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (done_cnt != d0 || err_cnt != e0) break;
        end
        repeat (3) begin @(negedge clk); #1; end
    endtask

    task automatic run_frame(input string tag, input int n, input logic [7:0] cmd,
                             input int chg_at, input logic [9:0] new_x, input bit exp_valid);
        logic [7:0] got, exp;
        int d0, e0;
        @(negedge clk);
        for (int i = 0; i < n; i++) exp_q.push_back(model_byte(i, x_pos, y_pos, btn));
        d0 = done_cnt;
        e0 = err_cnt;
        spi_if.joystick_SS = 1'b0;
        #80;
        for (int i = 0; i < n; i++) begin
            if (i == chg_at) x_pos = new_x;
            shift_byte((i == 0) ? cmd : 8'h00, got);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check({tag, "_miso_byte"}, {24'd0, got}, {24'd0, exp});
        end
        #80;
        spi_if.joystick_SS = 1'b1;
        wait_end(d0, e0);
        check({tag, "_done"}, done_cnt - d0, exp_valid ? 1 : 0);
        check({tag, "_err"},  err_cnt - e0,  exp_valid ? 0 : 1);
        if (exp_valid && cmd[7:2] == 6'b100000) exp_led = cmd[1:0];
        check({tag, "_led"}, {30'd0, led}, {30'd0, exp_led});
        #200;
    endtask

    initial begin
        logic [7:0] got;
        int d0, e0;
        rst = 1'b1;
        x_pos = 10'h2A5; y_pos = 10'h13C; btn = 3'b101;
        spi_if.joystick_SS = 1'b1; spi_if.joystick_SCLK = 1'b0; spi_if.joystick_MOSI = 1'b0;
        exp_led = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_miso", {31'd0, spi_if.joystick_MISO}, 32'd0);
        check("rst_led", {30'd0, led}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        run_frame("basic", 5, 8'h83, -1, 10'd0, 1'b1);
        run_frame("nocmd", 5, 8'h40, -1, 10'd0, 1'b1);
        run_frame("short", 3, 8'h81, -1, 10'd0, 1'b0);
        run_frame("after_short", 5, 8'h81, -1, 10'd0, 1'b1);
        run_frame("long", 6, 8'h82, -1, 10'd0, 1'b0);
        run_frame("xchg", 5, 8'h80, 1, 10'h1FF, 1'b1);
        run_frame("xnew", 5, 8'h83, -1, 10'd0, 1'b1);

        // Reset while a frame is in progress
        @(negedge clk);
        d0 = done_cnt;
        e0 = err_cnt;
        spi_if.joystick_SS = 1'b0;
        #80;
        shift_byte(8'h83, got);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_led", {30'd0, led}, 32'd0);
        check("midrst_miso", {31'd0, spi_if.joystick_MISO}, 32'd0);
        exp_led = 2'b00;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        shift_byte(8'h83, got);
        check("midrst_silent", {24'd0, got}, 32'd0);
        spi_if.joystick_SS = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_no_err", err_cnt - e0, 0);
        x_pos = 10'h0F3; y_pos = 10'h3C1; btn = 3'b010;
        run_frame("post_rst", 5, 8'h82, -1, 10'd0, 1'b1);

        check("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
